// File: rtl/chan_arb_fifo.sv
// Per-channel FIFOs feeding one output through a round-robin arbiter that holds its grant under backpressure.
// Define CHAN_ARB_FIFO_STATS_EN to add per-channel saturating grant counters on stat_grants.
module chan_arb_fifo #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    input  logic                       flush
`ifdef CHAN_ARB_FIFO_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]       stat_grants
`endif
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic              ready_en_q, ready_en_d;

    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
    logic [DATA_W-1:0] head_data [NUM_CH];

    logic [NUM_CH-1:0] not_empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [CH_W-1:0]   arb_sel;
    logic              arb_found;
    int                arb_idx;
    logic [CH_W-1:0]   cur_ch;
    logic              handshake;

    // in_ready depends only on registered state, never on out_ready.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            not_empty[c] = (count_q[c] != '0);
            in_ready[c]  = ready_en_q && (count_q[c] != CNT_W'(DEPTH));
        end
    end

    // First non-empty channel at or after rr_q, wrapping at NUM_CH.
    always_comb begin
        arb_sel   = '0;
        arb_found = 1'b0;
        arb_idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_idx = int'(rr_q) + i;
            if (arb_idx >= NUM_CH) begin
                arb_idx = arb_idx - NUM_CH;
            end
            if (!arb_found && not_empty[arb_idx]) begin
                arb_found = 1'b1;
                arb_sel   = CH_W'(arb_idx);
            end
        end
    end

    always_comb begin
        cur_ch    = (state_q == ST_HOLD) ? grant_q : arb_sel;
        out_valid = |not_empty;
        out_ch    = out_valid ? cur_ch : '0;
        out_data  = out_valid ? head_data[cur_ch] : '0;
        handshake = out_valid && out_ready;
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            push[c] = in_valid[c] && in_ready[c] && !flush;
            pop[c]  = handshake && !flush && (cur_ch == CH_W'(c));
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        ready_en_d = 1'b1;
        if (flush) begin
            state_d = ST_ARB;
            grant_d = '0;
            rr_d    = '0;
        end else if (handshake) begin
            state_d = ST_ARB;
            rr_d    = (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
        end else if (out_valid) begin
            // Stalled: freeze the channel currently presented.
            state_d = ST_HOLD;
            grant_d = cur_ch;
        end else begin
            state_d = ST_ARB;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            count_d[c]  = count_q[c];
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            if (flush) begin
                count_d[c]  = '0;
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
            end else begin
                if (push[c]) begin
                    wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
                end
                if (pop[c]) begin
                    rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
                end
                if (push[c] && !pop[c]) begin
                    count_d[c] = count_q[c] + 1'b1;
                end else if (pop[c] && !push[c]) begin
                    count_d[c] = count_q[c] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ARB;
            grant_q    <= '0;
            rr_q       <= '0;
            ready_en_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c]  <= '0;
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_q       <= rr_d;
            ready_en_q <= ready_en_d;
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c]  <= count_d[c];
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
        end
    end

    // Storage carries no reset: an entry is only observable once its count says so.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (push[gi]) begin
                mem[wr_ptr_q[gi]] <= in_data[gi*DATA_W +: DATA_W];
            end
        end

        assign head_data[gi] = mem[rd_ptr_q[gi]];
    end

`ifdef CHAN_ARB_FIFO_STATS_EN
    logic [15:0] stat_q [NUM_CH];
    logic [15:0] stat_d [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            stat_d[c] = stat_q[c];
            if (flush) begin
                stat_d[c] = '0;
            end else if (pop[c] && (stat_q[c] != 16'hFFFF)) begin
                stat_d[c] = stat_q[c] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                stat_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                stat_q[c] <= stat_d[c];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stat
        assign stat_grants[gi*16 +: 16] = stat_q[gi];
    end
`endif

endmodule

// File: tb/tb_chan_arb_fifo.sv
// Randomized and directed bench for chan_arb_fifo against a queue-based reference model.
module tb_chan_arb_fifo;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CH_W   = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     flush;
`ifdef CHAN_ARB_FIFO_STATS_EN
    logic [NUM_CH*16-1:0]     stat_grants;
`endif

    chan_arb_fifo #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .flush       (flush)
`ifdef CHAN_ARB_FIFO_STATS_EN
        ,
        .stat_grants (stat_grants)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one queue per channel, a round-robin start, and an optional held channel.
    logic [DATA_W-1:0] mq [NUM_CH][$];
    int                m_rr;
    int                m_hold;
    int unsigned       m_grants [NUM_CH];

    function automatic void m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            mq[c].delete();
            m_grants[c] = 0;
        end
        m_rr   = 0;
        m_hold = -1;
    endfunction

    function automatic int m_pick();
        int c;
        if (m_hold >= 0) return m_hold;
        for (int i = 0; i < NUM_CH; i++) begin
            c = (m_rr + i) % NUM_CH;
            if (mq[c].size() > 0) return c;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int g;
        logic [NUM_CH-1:0] exp_rdy;
        g = m_pick();
        for (int c = 0; c < NUM_CH; c++) exp_rdy[c] = (mq[c].size() < DEPTH);
        check_val("in_ready", in_ready, exp_rdy);
        check_val("out_valid", out_valid, (g >= 0));
        if (g >= 0) begin
            check_val("out_ch", out_ch, g);
            check_val("out_data", out_data, mq[g][0]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, out_valid, 0);
        check_val({tag, "_ch"}, out_ch, 0);
        check_val({tag, "_data"}, out_data, 0);
        check_val({tag, "_ready"}, in_ready, 0);
    endtask

    // Drive one cycle of inputs, advance the model by the same rules, clock, then compare.
    task automatic do_cycle(input logic [NUM_CH-1:0] iv, input logic [NUM_CH*DATA_W-1:0] id,
                            input logic ordy, input logic fl);
        int g;
        logic [NUM_CH-1:0] rdy;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        g = m_pick();
        for (int c = 0; c < NUM_CH; c++) rdy[c] = (mq[c].size() < DEPTH);
        if (fl) begin
            m_reset();
        end else begin
            if (g >= 0 && ordy) begin
                $display("xfer ch=%0d data=%02h", g, mq[g][0]);
                void'(mq[g].pop_front());
                m_rr   = (g + 1) % NUM_CH;
                m_hold = -1;
                if (m_grants[g] < 65535) m_grants[g]++;
            end else if (g >= 0) begin
                m_hold = g;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (iv[c] && rdy[c]) mq[c].push_back(id[c*DATA_W +: DATA_W]);
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] id;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b1;
        m_reset();
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rdy_after_rst", in_ready, 4'hF);
        check_outputs();

        // Single push on ch2, visible the next cycle, gone after the pop.
        id = '0;
        id[23:16] = 8'hA5;
        do_cycle(4'b0100, id, 1'b1, 1'b0);
        check_val("single_valid", out_valid, 1);
        check_val("single_ch", out_ch, 2);
        check_val("single_data", out_data, 8'hA5);
        do_cycle(4'b0000, '0, 1'b1, 1'b0);
        check_val("single_empty", out_valid, 0);

        // Round-robin across four channels holding two entries each.
        do_cycle('0, '0, 1'b0, 1'b1);
        do_cycle(4'hF, 32'h13_12_11_10, 1'b0, 1'b0);
        do_cycle(4'hF, 32'h23_22_21_20, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check_val("rr_seq", out_ch, k % NUM_CH);
            do_cycle('0, '0, 1'b1, 1'b0);
        end
        check_val("rr_drained", out_valid, 0);

        // Backpressure: ch1 held while ch0 and ch3 arrive.
        do_cycle('0, '0, 1'b0, 1'b1);
        id = '0;
        id[15:8] = 8'h3C;
        do_cycle(4'b0010, id, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            id = $urandom;
            do_cycle(4'b1001, id, 1'b0, 1'b0);
            check_val("hold_ch", out_ch, 1);
            check_val("hold_data", out_data, 8'h3C);
        end
        check_val("hold_first_pop", out_ch, 1);
        for (int k = 0; k < 10; k++) do_cycle('0, '0, 1'b1, 1'b0);

        // Full channel: four pushes, a fifth rejected, room again after one pop.
        do_cycle('0, '0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) do_cycle(4'b0001, 32'h40 + k, 1'b0, 1'b0);
        check_val("full_rdy0", in_ready[0], 0);
        do_cycle(4'b0001, 32'hEE, 1'b0, 1'b0);
        do_cycle('0, '0, 1'b1, 1'b0);
        check_val("full_rdy_after_pop", in_ready[0], 1);
        do_cycle(4'b0001, 32'h77, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) do_cycle('0, '0, 1'b1, 1'b0);

        // Flush beats a same-cycle handshake and same-cycle pushes; round-robin restarts at 0.
        do_cycle('0, '0, 1'b0, 1'b1);
        do_cycle(4'b0111, 32'h00_C2_B1_A0, 1'b0, 1'b0);
        do_cycle(4'hF, 32'h55_55_55_55, 1'b1, 1'b1);
        check_val("flush_valid", out_valid, 0);
        do_cycle(4'b1001, 32'h93_00_00_90, 1'b0, 1'b0);
        check_val("flush_rr0", out_ch, 0);
        for (int k = 0; k < 3; k++) do_cycle('0, '0, 1'b1, 1'b0);

        // Randomized traffic, light then heavy backpressure.
        for (int k = 0; k < 300; k++) begin
            id = $urandom;
            do_cycle(4'($urandom_range(0, 15)), id, ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 63) == 0));
        end
        for (int k = 0; k < 300; k++) begin
            id = $urandom;
            do_cycle(4'($urandom_range(0, 15)), id, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 99) == 0));
        end
`ifdef CHAN_ARB_FIFO_STATS_EN
        for (int c = 0; c < NUM_CH; c++) check_val("stat_model", stat_grants[c*16 +: 16], m_grants[c]);
`endif

        // Reset in the middle of buffered traffic.
        do_cycle(4'hF, 32'h0F_0E_0D_0C, 1'b0, 1'b0);
        do_cycle(4'hF, 32'h1F_1E_1D_1C, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        in_valid  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk) rst_n = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        check_val("rst_rdy", in_ready, 4'hF);
        check_outputs();

`ifdef CHAN_ARB_FIFO_STATS_EN
        // Saturation: one grant per cycle on ch1 well beyond 16 bits.
        do_cycle('0, '0, 1'b0, 1'b1);
        in_valid  = 4'b0010;
        in_data   = 32'h0000_5A00;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (70001) @(posedge clk);
        #1;
        check_val("stat_sat_ch1", stat_grants[31:16], 16'hFFFF);
        check_val("stat_sat_ch0", stat_grants[15:0], 16'h0000);
        in_valid = '0;
        do_cycle('0, '0, 1'b0, 1'b1);
        check_val("stat_flush", stat_grants, '0);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/chan_arb_fifo.md
CHAN_ARB_FIFO -- requirements
Module: chan_arb_fifo

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of input channels, 2..16.
REQ-002 SHALL have parameter DATA_W, default 8: payload width per channel, 1..64.
REQ-003 SHALL have parameter DEPTH, default 4: entries per channel FIFO, a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, NUM_CH bits: per-channel offer.
REQ-007 SHALL have port in_ready, output, NUM_CH bits: per-channel accept.
REQ-008 SHALL have port in_data, input, NUM_CH*DATA_W bits: channel c occupies bits [c*DATA_W +: DATA_W].
REQ-009 SHALL have port out_valid, output, 1 bit: an entry is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the sink accepts.
REQ-011 SHALL have port out_data, output, DATA_W bits: the presented payload.
REQ-012 SHALL have port out_ch, output, $clog2(NUM_CH) bits: the source channel of out_data.
REQ-013 SHALL have port flush, input, 1 bit: synchronous clear.

Function
REQ-014 SHALL push into channel c's FIFO when in_valid[c] and in_ready[c] are both high; in_ready[c] = (count[c] != DEPTH).
REQ-015 SHALL keep in_ready free of any combinational path from out_ready; a full channel does not accept in the cycle it pops.
REQ-016 SHALL present an entry pushed in cycle N on the output no earlier than cycle N+1; there is no bypass.
REQ-017 SHALL use a two-state FSM: ARB selects the first non-empty channel at or after rr_ptr, modulo NUM_CH; HOLD applies while out_valid is high and out_ready is low.
REQ-018 SHALL drive out_valid high whenever any FIFO is non-empty, with out_data and out_ch taken from the selected channel's head.
REQ-019 SHALL move ARB->HOLD on out_valid && !out_ready; while in HOLD, out_ch, out_data and out_valid remain stable until the handshake, regardless of new arrivals.
REQ-020 SHALL, on a handshake (out_valid && out_ready), pop the granted FIFO, set rr_ptr = granted + 1 (wrapping NUM_CH-1 to 0), and return to ARB.
REQ-021 SHALL allow a push and a pop on the same non-full channel in the same cycle, leaving the count unchanged.
REQ-022 SHALL wrap the FIFO read and write pointers modulo DEPTH and keep each count in 0..DEPTH.
REQ-023 SHALL, on flush, empty all FIFOs, set rr_ptr to 0, enter ARB and ignore same-cycle pushes; out_valid is low the next cycle.
REQ-024 SHALL give flush priority over a same-cycle handshake; the popped entry is discarded.

Reset
REQ-025 SHALL, while rst_n is low, asynchronously force: all counts 0, rr_ptr 0, FSM ARB, out_valid 0, out_ch 0, out_data 0, in_ready all 0.
REQ-026 SHALL drive in_ready all 1 from the first clock edge after rst_n deasserts.
REQ-027 SHALL, when reset asserts mid-transfer, lose all buffered entries without producing a partial output.

Configuration
REQ-028 SHALL, when macro CHAN_ARB_FIFO_STATS_EN is defined, add output stat_grants, NUM_CH*16 bits: per-channel 16-bit saturating handshake counters, cleared by reset and by flush, holding at 16'hFFFF.
REQ-029 SHALL, without CHAN_ARB_FIFO_STATS_EN, omit the stat_grants port and the counter logic entirely, with all other behaviour identical.

Verification
REQ-030 SHALL check single push: ch2 pushes 8'hA5 in cycle N with out_ready=1 -> out_valid=1, out_ch=2, out_data=8'hA5 in cycle N+1, and the FIFO is empty at N+2.
REQ-031 SHALL check round-robin: all 4 channels hold 2 entries with out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3.
REQ-032 SHALL check backpressure: out_ready=0 for 5 cycles while ch3 pushes behind a held ch1 -> out_ch=1 and out_data are stable for all 5 cycles, then ch1 is popped first.
REQ-033 SHALL check full: 4 pushes into ch0 with out_ready=0 -> in_ready[0]=0; a 5th offer is not accepted; after one pop, in_ready[0]=1 the next cycle.
REQ-034 SHALL check flush and reset: flush during a handshake with 3 entries buffered -> out_valid=0 next cycle and rr_ptr=0; rst_n pulsed low mid-stream -> all outputs 0 immediately.
REQ-035 SHALL check stats with CHAN_ARB_FIFO_STATS_EN defined: 70000 grants on ch1 -> stat_grants[31:16] = 16'hFFFF.
